i2s_dac_tx: RTL



---
 rtl/audio_pkg.sv | 6 +
 rtl/sample_fifo.sv | 46 ++++
 rtl/i2s_dac_tx.sv | 111 +++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared audio sample type and transmitter state encoding
package audio_pkg;
  localparam int AUDIO_W = 16;
  typedef logic signed [AUDIO_W-1:0] sample_t;
  typedef enum logic [1:0] {S_WAIT, S_DELAY, S_SHIFT, S_PAD} tx_state_e;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous FIFO with the head word readable combinationally for a same-cycle pop
module sample_fifo
  import audio_pkg::*;
#(
  parameter int W = AUDIO_W,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [LW-1:0] o_level
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  always_comb begin
    wr_d = i_push ? wr_q + AW'(1) : wr_q;
    rd_d = i_pop ? rd_q + AW'(1) : rd_q;
    level_d = level_q + LW'(i_push) - LW'(i_pop);
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      level_q <= level_d;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_push) mem_q[wr_q] <= i_data;
  end
  assign o_head = mem_q[rd_q];
  assign o_full = level_q == LW'(DEPTH);
  assign o_empty = level_q == '0;
  assign o_level = level_q;
endmodule

// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: FIFO-buffered mono sample stream serialised onto both I2S DAC channels
// Define I2S_TX_LJ_EN for left-justified framing (no one-BCLK delay slot).
module i2s_dac_tx
  import audio_pkg::*;
#(
  parameter int DATA_W = AUDIO_W,
  parameter int FIFO_DEPTH = 4,
  localparam int LW = $clog2(FIFO_DEPTH) + 1,
  localparam int CW = $clog2(DATA_W)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  input  logic signed [DATA_W-1:0] i_data,
  input  logic                     i_aud_bclk,
  input  logic                     i_aud_daclrck,
  output logic                     o_aud_dacdat,
  output logic                     o_overflow,
  output logic                     o_underflow,
  output logic [LW-1:0]            o_fifo_level
);
  // [0] and [1] synchronise, [2] holds history for edge detection
  logic [2:0] bclk_q, bclk_d, lrc_q, lrc_d;
  tx_state_e state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d, cur_q, cur_d, head;
  logic [CW-1:0] cnt_q, cnt_d;
  logic dat_q, dat_d, ovf_q, ovf_d, unf_q, unf_d;
  logic bclk_fall, lrc_fall, frame, push, pop, full, empty;
  sample_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_data  (i_data),
    .i_pop   (pop),
    .o_head  (head),
    .o_full  (full),
    .o_empty (empty),
    .o_level (o_fifo_level)
  );
  always_comb begin
    bclk_d = {bclk_q[1:0], i_aud_bclk};
    lrc_d = {lrc_q[1:0], i_aud_daclrck};
    bclk_fall = !bclk_q[1] && bclk_q[2];
    lrc_fall = !lrc_q[1] && lrc_q[2];
    // LRCK only changes on a BCLK fall, so gating keeps output updates on fall detects
    frame = bclk_fall && (lrc_q[1] != lrc_q[2]);
    pop = frame && lrc_fall && !empty;
    push = i_valid && (!full || pop);
    ovf_d = ovf_q || (i_valid && full && !pop);
    unf_d = unf_q || (frame && lrc_fall && empty);
    cur_d = pop ? head : cur_q;
    state_d = state_q;
    sh_d = sh_q;
    cnt_d = cnt_q;
    dat_d = dat_q;
    if (frame) begin
`ifdef I2S_TX_LJ_EN
      state_d = S_SHIFT;
      dat_d = cur_d[DATA_W-1];
      sh_d = cur_d << 1;
      cnt_d = CW'(DATA_W - 1);
`else
      state_d = S_DELAY;
      dat_d = 1'b0;
      sh_d = cur_d;
`endif
    end else if (bclk_fall) begin
      case (state_q)
        S_DELAY: begin
          state_d = S_SHIFT;
          dat_d = sh_q[DATA_W-1];
          sh_d = sh_q << 1;
          cnt_d = CW'(DATA_W - 1);
        end
        S_SHIFT: begin
          state_d = cnt_q == '0 ? S_PAD : S_SHIFT;
          dat_d = cnt_q == '0 ? 1'b0 : sh_q[DATA_W-1];
          sh_d = sh_q << 1;
          cnt_d = cnt_q - CW'(1);
        end
        default: dat_d = 1'b0;
      endcase
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bclk_q <= '0;
      lrc_q <= '0;
      state_q <= S_WAIT;
      sh_q <= '0;
      cur_q <= '0;
      cnt_q <= '0;
      dat_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      bclk_q <= bclk_d;
      lrc_q <= lrc_d;
      state_q <= state_d;
      sh_q <= sh_d;
      cur_q <= cur_d;
      cnt_q <= cnt_d;
      dat_q <= dat_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  assign o_aud_dacdat = dat_q;
  assign o_overflow = ovf_q;
  assign o_underflow = unf_q;
endmodule
